// File: rtl/median_ctrl_if.sv
// Handshake bundle between the pixel source / pipeline and the median sequencing controller.
// master drives the sample strobe, slave (the controller) drives the schedule and status.
interface median_ctrl_if;
  logic DSI;
  logic BYP;
  logic DSO;
  logic BUSY;
  logic ERR;

  modport master (output DSI, input BYP, DSO, BUSY, ERR);
  modport slave  (input DSI, output BYP, DSO, BUSY, ERR);
endinterface

// File: rtl/median_ctrl.sv
// Sequencer for the 9-sample median datapath: counts the DSI window, drives the BYP
// schedule of the iterative max-extraction sort and flags the median with DSO.
module median_ctrl #(
  parameter int width  = 8,
  parameter int number = 9
) (
  input  logic        CLK,
  input  logic        RST,
  median_ctrl_if.slave bus
);
  localparam int CW  = $clog2(number + 1);
  localparam int CW1 = CW + 1;
  localparam int P   = (number - 1) / 2;

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] N_FULL  = CW'(number);
  localparam logic [CW-1:0] C_LAST  = CW'(number - 1);
  localparam logic [CW-1:0] P_LAST  = CW'(P - 1);
  localparam logic [CW1-1:0] BYP_LIM = CW1'(number - 2);

  generate
    if (width < 1 || number < 3 || (number % 2) == 0) begin : g_bad_params
      $error("median_ctrl: width must be >= 1 and number odd and >= 3");
    end
  endgenerate

  // DRAIN holds off after an over-long strobe until DSI finally drops.
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, SORT, FINAL, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cyc_reg, cyc_next;
  logic [CW-1:0] pass_reg, pass_next;
  logic          dsi_prev_reg;
  logic          byp_reg, byp_next;
  logic          dso_reg, dso_next;
  logic          busy_reg, busy_next;
  logic          err_reg, err_next;
  logic          dsi_rise;

  assign dsi_rise = bus.DSI & ~dsi_prev_reg;

  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    pass_next  = pass_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.DSI) begin
          state_next = LOAD;
          cyc_next   = ONE;
        end
      end
      LOAD: begin
        if (bus.DSI) begin
          if (cyc_reg == N_FULL) begin
            err_next   = 1'b1;
            state_next = DRAIN;
            cyc_next   = '0;
          end else begin
            cyc_next = cyc_reg + ONE;
          end
        end else if (cyc_reg == N_FULL) begin
          state_next = SORT;
          pass_next  = '0;
          cyc_next   = '0;
        end else begin
          err_next   = 1'b1;
          state_next = IDLE;
          cyc_next   = '0;
        end
      end
      DRAIN: begin
        if (!bus.DSI) state_next = IDLE;
      end
      SORT: begin
        // Strobe activity here is a source fault only; the sort keeps running.
        err_next = dsi_rise;
        if (cyc_reg == C_LAST) begin
          cyc_next = '0;
          if (pass_reg == P_LAST) state_next = FINAL;
          else                    pass_next  = pass_reg + ONE;
        end else begin
          cyc_next = cyc_reg + ONE;
        end
      end
      FINAL: begin
        err_next = dsi_rise;
        if (cyc_reg == P_LAST) begin
          state_next = DONE;
          cyc_next   = '0;
        end else begin
          cyc_next = cyc_reg + ONE;
        end
      end
      DONE: begin
        pass_next = '0;
        if (bus.DSI) begin
          state_next = LOAD;
          cyc_next   = ONE;
        end else begin
          state_next = IDLE;
          cyc_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cyc_next   = '0;
        pass_next  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered with it.
  always_comb begin
    byp_next  = 1'b1;
    dso_next  = 1'b0;
    busy_next = 1'b0;
    case (state_next)
      LOAD:  busy_next = 1'b1;
      SORT: begin
        busy_next = 1'b1;
        byp_next  = (({1'b0, cyc_next} + {1'b0, pass_next}) > BYP_LIM);
      end
      FINAL: begin
        busy_next = 1'b1;
        byp_next  = 1'b0;
      end
      DONE: begin
        busy_next = 1'b1;
        dso_next  = 1'b1;
      end
      default: begin
        byp_next  = 1'b1;
        busy_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      cyc_reg      <= '0;
      pass_reg     <= '0;
      dsi_prev_reg <= 1'b0;
      byp_reg      <= 1'b1;
      dso_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cyc_reg      <= cyc_next;
      pass_reg     <= pass_next;
      dsi_prev_reg <= bus.DSI;
      byp_reg      <= byp_next;
      dso_reg      <= dso_next;
      busy_reg     <= busy_next;
      err_reg      <= err_next;
    end
  end

  assign bus.BYP  = byp_reg;
  assign bus.DSO  = dso_reg;
  assign bus.BUSY = busy_reg;
  assign bus.ERR  = err_reg;
endmodule

// File: tb/tb_median_ctrl.sv
// Randomised window stream for median_ctrl; expected ERR/DSO events are queued up front
// and a negedge monitor pops and checks them as the controller reports.
module tb_median_ctrl;
  localparam int N     = 9;
  localparam int P     = (N - 1) / 2;
  localparam int SCHED = N * P + P + 1;
  localparam int MAXC  = 4096;

  localparam int K_NOM = 0, K_SHORT = 1, K_LONG = 2, K_INTR = 3;
  localparam int EV_ERR = 0, EV_DSO = 1;

  typedef struct packed {
    int          kind;
    int          cyc;
    logic        busy;
    int          start;
    int          sstart;
    logic [63:0] pat;
  } ev_t;

  ev_t exp_q[$];

  logic CLK = 1'b0;
  logic RST = 1'b1;
  median_ctrl_if bus_if ();

  median_ctrl #(.width(8), .number(N)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  always #5 CLK = ~CLK;

  int cycle = 0;
  always @(posedge CLK) cycle <= cycle + 1;

  logic dsi_plan  [MAXC];
  logic byp_hist  [MAXC];
  logic busy_hist [MAXC];
  int checks = 0;
  int passes = 0;
  int plan_len;
  int rst_cycle;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, req, cycle);
  endtask

  // Reference BYP trace from SORT entry to DONE: pass i compares N-1-i times then
  // bypasses i+1 times, FINAL compares P times, DONE bypasses.
  function automatic logic [63:0] sched_pat();
    logic [63:0] p;
    int k;
    p = '0;
    k = 0;
    for (int i = 0; i < P; i++)
      for (int c = 0; c < N; c++) begin
        p[k] = (c >= N - 1 - i);
        k++;
      end
    for (int c = 0; c < P; c++) begin
      p[k] = 1'b0;
      k++;
    end
    p[k] = 1'b1;
    return p;
  endfunction

  task automatic plan_window(input int kind, input int len, input int s,
                             input int ipos, input int ilen, output int nxt);
    ev_t e;
    int ss, d, x, k;
    for (int t = s; t < s + len; t++) dsi_plan[t] = 1'b1;
    ss = s + N + 1;
    d  = ss + N * P + P;
    e = '0;
    e.start  = s;
    e.sstart = ss;
    if (kind == K_SHORT) begin
      e.kind = EV_ERR; e.cyc = s + len + 1; e.busy = 1'b0;
      exp_q.push_back(e);
      nxt = s + len + 1;
    end else if (kind == K_LONG) begin
      e.kind = EV_ERR; e.cyc = s + N + 1; e.busy = 1'b0;
      exp_q.push_back(e);
      nxt = s + len + 1;
    end else begin
      if (kind == K_INTR) begin
        k = (ilen > 0) ? ilen : int'($urandom_range(1, 3));
        x = (ipos > 0) ? ipos : int'($urandom_range(ss, d - 1 - k));
        for (int t = x; t < x + k; t++) dsi_plan[t] = 1'b1;
        e.kind = EV_ERR; e.cyc = x + 1; e.busy = 1'b1;
        exp_q.push_back(e);
      end
      e.kind = EV_DSO; e.cyc = d; e.busy = 1'b1; e.pat = sched_pat();
      exp_q.push_back(e);
      nxt = d;
    end
  endtask

  task automatic handle(input int kind);
    ev_t e;
    logic [63:0] act;
    int bcnt;
    $display("cycle %0d: %s observed, BUSY=%0b", cycle, (kind == EV_DSO) ? "DSO" : "ERR", bus_if.BUSY);
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: actual %s at cycle %0d, required none", (kind == EV_DSO) ? "DSO" : "ERR", cycle);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      check("event_cycle", 64'(cycle), 64'(e.cyc));
      if (kind == EV_DSO && e.kind == EV_DSO) begin
        act = '0;
        for (int k = 0; k < SCHED; k++)
          if (e.sstart + k < MAXC) act[k] = byp_hist[e.sstart + k];
        check("byp_sched", act, e.pat);
        bcnt = 0;
        for (int c = e.start + 1; c <= cycle && c < MAXC; c++)
          if (busy_hist[c] === 1'b1) bcnt++;
        check("busy_span", 64'(bcnt), 64'(e.cyc - e.start));
      end else if (kind == EV_ERR) begin
        check("err_busy", 64'(bus_if.BUSY), 64'(e.busy));
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (cycle < MAXC) begin
        byp_hist[cycle]  = bus_if.BYP;
        busy_hist[cycle] = bus_if.BUSY;
      end
      if (bus_if.ERR === 1'b1) handle(EV_ERR);
      if (bus_if.DSO === 1'b1) handle(EV_DSO);
    end
  end

  initial begin
    int t, nxt, kind, len;
    for (int i = 0; i < MAXC; i++) dsi_plan[i] = 1'b0;
    bus_if.DSI = 1'b0;

    // Window aborted by reset in SORT pass 2, cycle 3.
    t = 4;
    for (int i = t; i < t + N; i++) dsi_plan[i] = 1'b1;
    rst_cycle = t + N + 1 + 2 * N + 3;
    t = rst_cycle + 3;

    plan_window(K_NOM, N, t, 0, 0, nxt);      t = nxt + 2;
    plan_window(K_SHORT, 5, t, 0, 0, nxt);    t = nxt + 1;
    plan_window(K_LONG, 10, t, 0, 0, nxt);    t = nxt + 2;
    plan_window(K_INTR, N, t, t + N + 1 + N + 2, 2, nxt); t = nxt + 3;
    plan_window(K_NOM, N, t, 0, 0, nxt);      t = nxt;
    plan_window(K_NOM, N, t, 0, 0, nxt);      t = nxt + 1;
    for (int w = 0; w < 25; w++) begin
      kind = int'($urandom_range(0, 3));
      len  = (kind == K_SHORT) ? int'($urandom_range(1, N - 1)) :
             (kind == K_LONG)  ? int'($urandom_range(N + 1, N + 3)) : N;
      plan_window(kind, len, t, 0, 0, nxt);
      t = nxt + int'($urandom_range(0, 3));
    end
    plan_len = t + 5;
    if (plan_len + 60 >= MAXC) begin
      $display("FAIL plan_length: actual %0d, required below %0d", plan_len + 60, MAXC);
      $fatal(1, "stimulus plan too long");
    end

    @(posedge CLK); #3;
    check("reset_byp", 64'(bus_if.BYP), 64'd1);
    check("reset_dso", 64'(bus_if.DSO), 64'd0);
    check("reset_busy", 64'(bus_if.BUSY), 64'd0);
    check("reset_err", 64'(bus_if.ERR), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    while (cycle < plan_len + 60) begin
      @(posedge CLK); #1;
      bus_if.DSI = dsi_plan[cycle];
      if (cycle == rst_cycle) begin
        #1;
        check("pre_reset_busy", 64'(bus_if.BUSY), 64'd1);
        #1 RST = 1'b1;
        #1;
        check("async_rst_byp", 64'(bus_if.BYP), 64'd1);
        check("async_rst_dso", 64'(bus_if.DSO), 64'd0);
        check("async_rst_busy", 64'(bus_if.BUSY), 64'd0);
        check("async_rst_err", 64'(bus_if.ERR), 64'd0);
      end else if (cycle == rst_cycle + 1) begin
        RST = 1'b0;
      end
    end

    check("pending_events", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
